// File: rtl/cu_pkg.sv
// Shared encodings and stage-control payloads for the pipelined RISC-V control unit.
package cu_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned IMM_SRC_W = 3;
  localparam int unsigned RES_SRC_W = 2;
  localparam int unsigned ALU_CTRL_W = 4;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [IMM_SRC_W-1:0] IMM_I = 3'b000;
  localparam logic [IMM_SRC_W-1:0] IMM_S = 3'b001;
  localparam logic [IMM_SRC_W-1:0] IMM_B = 3'b010;
  localparam logic [IMM_SRC_W-1:0] IMM_J = 3'b011;
  localparam logic [IMM_SRC_W-1:0] IMM_U = 3'b100;

  localparam logic [RES_SRC_W-1:0] RES_ALU = 2'b00;
  localparam logic [RES_SRC_W-1:0] RES_MEM = 2'b01;
  localparam logic [RES_SRC_W-1:0] RES_PC4 = 2'b10;
  localparam logic [RES_SRC_W-1:0] RES_IMM = 2'b11;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLL  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001,
    ALU_MUL  = 4'b1010,
    ALU_MULH = 4'b1011,
    ALU_DIV  = 4'b1100,
    ALU_REM  = 4'b1101
  } alu_op_e;

  typedef struct packed {
    logic                 reg_write;
    logic [RES_SRC_W-1:0] result_src;
    logic                 mem_write;
    logic                 jump;
    logic                 branch;
    logic                 jalr;
    logic                 load;
    logic                 byte_address;
    logic                 alu_src;
    alu_op_e              alu_control;
    logic [2:0]           funct3;
  } ctrl_t;

  typedef struct packed {
    logic                 reg_write;
    logic [RES_SRC_W-1:0] result_src;
    logic                 mem_write;
    logic                 byte_address;
  } mctrl_t;

  typedef struct packed {
    logic                 reg_write;
    logic [RES_SRC_W-1:0] result_src;
  } wctrl_t;

  localparam ctrl_t  CTRL_BUBBLE  = '0;
  localparam mctrl_t MCTRL_BUBBLE = '0;
  localparam wctrl_t WCTRL_BUBBLE = '0;

  // Base integer ALU op shared by R-type and I-type; only R-type may select SUB.
  function automatic alu_op_e alu_base(input logic [2:0] f3, input logic f7b5, input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  // Branch condition from flags of rs1-rs2; carry set means no borrow (rs1 >= rs2 unsigned).
  function automatic logic branch_cond(input logic [2:0] f3, input logic zero, input logic neg,
                                       input logic ovf, input logic carry);
    case (f3)
      3'b000:  return zero;
      3'b001:  return !zero;
      3'b100:  return neg ^ ovf;
      3'b101:  return !(neg ^ ovf);
      3'b110:  return !carry;
      3'b111:  return carry;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational D-stage decode: instruction fields to stage controls, immediate select and illegal flag.
module cu_decode
  import cu_pkg::*;
#(
  parameter bit EXT_M = 1'b0
) (
  input  logic [6:0]           opcode_i,
  input  logic [2:0]           funct3_i,
  input  logic [6:0]           funct7_i,
  output ctrl_t                ctrl_o,
  output logic [IMM_SRC_W-1:0] imm_src_o,
  output logic                 illegal_o
);

  always_comb begin
    ctrl_o        = CTRL_BUBBLE;
    imm_src_o     = IMM_I;
    illegal_o     = 1'b0;
    ctrl_o.funct3 = funct3_i;

    case (opcode_i)
      OP_LOAD: begin
        ctrl_o.reg_write    = 1'b1;
        ctrl_o.result_src   = RES_MEM;
        ctrl_o.alu_src      = 1'b1;
        ctrl_o.load         = 1'b1;
        ctrl_o.byte_address = (funct3_i == 3'b000);
      end
      OP_STORE: begin
        ctrl_o.mem_write    = 1'b1;
        ctrl_o.alu_src      = 1'b1;
        ctrl_o.byte_address = (funct3_i == 3'b000);
        imm_src_o           = IMM_S;
      end
      OP_R: begin
        ctrl_o.reg_write = 1'b1;
        if (funct7_i == F7_MULDIV) begin
          if (!EXT_M) begin
            illegal_o = 1'b1;
          end else begin
            case (funct3_i)
              3'b000:  ctrl_o.alu_control = ALU_MUL;
              3'b001:  ctrl_o.alu_control = ALU_MULH;
              3'b100:  ctrl_o.alu_control = ALU_DIV;
              3'b110:  ctrl_o.alu_control = ALU_REM;
              default: illegal_o = 1'b1;
            endcase
          end
        end else begin
          ctrl_o.alu_control = alu_base(funct3_i, funct7_i[5], 1'b1);
        end
      end
      OP_IMM: begin
        ctrl_o.reg_write   = 1'b1;
        ctrl_o.alu_src     = 1'b1;
        ctrl_o.alu_control = alu_base(funct3_i, funct7_i[5], 1'b0);
      end
      OP_BRANCH: begin
        ctrl_o.branch      = 1'b1;
        ctrl_o.alu_control = ALU_SUB;
        imm_src_o          = IMM_B;
        illegal_o          = (funct3_i == 3'b010) || (funct3_i == 3'b011);
      end
      OP_JAL: begin
        ctrl_o.jump       = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_PC4;
        imm_src_o         = IMM_J;
      end
      OP_JALR: begin
        ctrl_o.jump       = 1'b1;
        ctrl_o.jalr       = 1'b1;
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_PC4;
        ctrl_o.alu_src    = 1'b1;
      end
      OP_LUI: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.result_src = RES_IMM;
        imm_src_o         = IMM_U;
      end
      OP_AUIPC: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        imm_src_o        = IMM_U;
      end
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit_pipe.sv
// Pipelined control unit: combinational decode in D, control registers for E, M and W
// with stall/flush handling and E-stage branch resolution.
module control_unit_pipe
  import cu_pkg::*;
#(
  parameter bit EXT_M          = 1'b0,
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] instr_i,
  input  logic        stall_i,
  input  logic        flush_e_i,
  input  logic        zero_i,
  input  logic        neg_i,
  input  logic        ovf_i,
  input  logic        carry_i,
  output logic [2:0]  imm_src_d_o,
  output logic        illegal_d_o,
  output logic [3:0]  alu_control_e_o,
  output logic        alu_src_e_o,
  output logic        pc_src_e_o,
  output logic        jalr_e_o,
  output logic        load_e_o,
  output logic        mem_write_m_o,
  output logic        byte_address_m_o,
  output logic        reg_write_m_o,
  output logic        reg_write_w_o,
  output logic [1:0]  result_src_w_o
);

  ctrl_t  dec_c;
  ctrl_t  dec_safe_c;
  ctrl_t  e_d, e_q;
  mctrl_t m_d, m_q;
  wctrl_t w_d, w_q;

  // Register and immediate fields are consumed by the datapath, not here.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_i[24:15], instr_i[11:7]};

  cu_decode #(
    .EXT_M(EXT_M)
  ) u_decode (
    .opcode_i (instr_i[6:0]),
    .funct3_i (instr_i[14:12]),
    .funct7_i (instr_i[31:25]),
    .ctrl_o   (dec_c),
    .imm_src_o(imm_src_d_o),
    .illegal_o(illegal_d_o)
  );

  // An illegal instruction must never write state or redirect the PC.
  always_comb begin
    dec_safe_c = dec_c;
    if (illegal_d_o) begin
      if (ILLEGAL_AS_NOP) begin
        dec_safe_c = CTRL_BUBBLE;
      end else begin
        dec_safe_c.reg_write   = 1'b0;
        dec_safe_c.mem_write   = 1'b0;
        dec_safe_c.branch      = 1'b0;
        dec_safe_c.jump        = 1'b0;
        dec_safe_c.jalr        = 1'b0;
        dec_safe_c.load        = 1'b0;
        dec_safe_c.alu_control = ALU_ADD;
      end
    end
  end

  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (!stall_i) begin
      e_d = flush_e_i ? CTRL_BUBBLE : dec_safe_c;
      m_d = '{reg_write:    e_q.reg_write,
              result_src:   e_q.result_src,
              mem_write:    e_q.mem_write,
              byte_address: e_q.byte_address};
      w_d = '{reg_write:  m_q.reg_write,
              result_src: m_q.result_src};
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      e_q <= CTRL_BUBBLE;
      m_q <= MCTRL_BUBBLE;
      w_q <= WCTRL_BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign alu_control_e_o  = 4'(e_q.alu_control);
  assign alu_src_e_o      = e_q.alu_src;
  assign jalr_e_o         = e_q.jalr;
  assign load_e_o         = e_q.load;
  // Flags are live, so a branch held in E by a stall keeps re-resolving.
  assign pc_src_e_o       = e_q.jump |
                            (e_q.branch & branch_cond(e_q.funct3, zero_i, neg_i, ovf_i, carry_i));
  assign mem_write_m_o    = m_q.mem_write;
  assign byte_address_m_o = m_q.byte_address;
  assign reg_write_m_o    = m_q.reg_write;
  assign reg_write_w_o    = w_q.reg_write;
  assign result_src_w_o   = w_q.result_src;

endmodule

// File: tb/tb_control_unit_pipe.sv
// Scoreboard bench for control_unit_pipe: stimulus queues expected values, a negedge monitor checks them.
module tb_control_unit_pipe;

  typedef enum int {
    S_IMM, S_ILL, S_ALU, S_ALUSRC, S_PCSRC, S_JALR, S_LOAD,
    S_MW, S_BA, S_RWM, S_RWW, S_RS, S_ILL_M, S_ALU_M
  } sig_e;

  typedef struct {
    int         due;
    sig_e       sig;
    logic [3:0] val;
    string      name;
  } exp_t;

  localparam logic [31:0] I_NOP  = 32'h00000013;
  localparam logic [31:0] I_SUB  = 32'h40B50533;
  localparam logic [31:0] I_LW   = 32'h00012083;
  localparam logic [31:0] I_BLT  = 32'h00B54063;
  localparam logic [31:0] I_BGEU = 32'h00B57063;
  localparam logic [31:0] I_BLTU = 32'h00B56063;
  localparam logic [31:0] I_JAL  = 32'h000000EF;
  localparam logic [31:0] I_SB   = 32'h00B50023;
  localparam logic [31:0] I_MUL  = 32'h02B50533;
  localparam logic [31:0] I_BILL = 32'h00B52063;
  localparam logic [31:0] I_JALR = 32'h00008067;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   cyc = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        stall, flush, zero, neg, ovf, carry;

  logic [2:0] imm_src, imm_src_m;
  logic       illegal, illegal_m;
  logic [3:0] alu_ctl, alu_ctl_m;
  logic       alu_src, alu_src_m, pc_src, pc_src_m, jalr, jalr_m, load, load_m;
  logic       mem_write, mem_write_m, byte_addr, byte_addr_m, rw_m, rw_m_m, rw_w, rw_w_m;
  logic [1:0] res_w, res_w_m;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  control_unit_pipe #(.EXT_M(1'b0), .ILLEGAL_AS_NOP(1'b1)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .instr_i(instr), .stall_i(stall), .flush_e_i(flush),
    .zero_i(zero), .neg_i(neg), .ovf_i(ovf), .carry_i(carry),
    .imm_src_d_o(imm_src), .illegal_d_o(illegal), .alu_control_e_o(alu_ctl),
    .alu_src_e_o(alu_src), .pc_src_e_o(pc_src), .jalr_e_o(jalr), .load_e_o(load),
    .mem_write_m_o(mem_write), .byte_address_m_o(byte_addr), .reg_write_m_o(rw_m),
    .reg_write_w_o(rw_w), .result_src_w_o(res_w)
  );

  control_unit_pipe #(.EXT_M(1'b1), .ILLEGAL_AS_NOP(1'b1)) dut_m (
    .clk_i(clk), .rst_n_i(rst_n), .instr_i(instr), .stall_i(stall), .flush_e_i(flush),
    .zero_i(zero), .neg_i(neg), .ovf_i(ovf), .carry_i(carry),
    .imm_src_d_o(imm_src_m), .illegal_d_o(illegal_m), .alu_control_e_o(alu_ctl_m),
    .alu_src_e_o(alu_src_m), .pc_src_e_o(pc_src_m), .jalr_e_o(jalr_m), .load_e_o(load_m),
    .mem_write_m_o(mem_write_m), .byte_address_m_o(byte_addr_m), .reg_write_m_o(rw_m_m),
    .reg_write_w_o(rw_w_m), .result_src_w_o(res_w_m)
  );

  function automatic logic [3:0] actual(input sig_e s);
    case (s)
      S_IMM:    return 4'(imm_src);
      S_ILL:    return 4'(illegal);
      S_ALU:    return alu_ctl;
      S_ALUSRC: return 4'(alu_src);
      S_PCSRC:  return 4'(pc_src);
      S_JALR:   return 4'(jalr);
      S_LOAD:   return 4'(load);
      S_MW:     return 4'(mem_write);
      S_BA:     return 4'(byte_addr);
      S_RWM:    return 4'(rw_m);
      S_RWW:    return 4'(rw_w);
      S_RS:     return 4'(res_w);
      S_ILL_M:  return 4'(illegal_m);
      default:  return alu_ctl_m;
    endcase
  endfunction

  task automatic push(input int dly, input sig_e s, input logic [3:0] v, input string nm);
    exp_t e;
    e.due  = cyc + dly;
    e.sig  = s;
    e.val  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic push_all_zero(input string nm);
    push(0, S_ALU, 4'd0, {nm, "_alu"});
    push(0, S_ALUSRC, 4'd0, {nm, "_alusrc"});
    push(0, S_PCSRC, 4'd0, {nm, "_pcsrc"});
    push(0, S_JALR, 4'd0, {nm, "_jalr"});
    push(0, S_LOAD, 4'd0, {nm, "_load"});
    push(0, S_MW, 4'd0, {nm, "_memw"});
    push(0, S_BA, 4'd0, {nm, "_byte"});
    push(0, S_RWM, 4'd0, {nm, "_rwm"});
    push(0, S_RWW, 4'd0, {nm, "_rww"});
    push(0, S_RS, 4'd0, {nm, "_ressrc"});
    push(0, S_ALU_M, 4'd0, {nm, "_alu_extm"});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: retire every expectation due this cycle, mid-cycle.
  always @(negedge clk) begin
    logic [3:0] act;
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].due == cyc) begin
        act = actual(sb_q[i].sig);
        n_vec++;
        if (act !== sb_q[i].val) begin
          n_miss++;
          $display("FAIL %s cycle %0d: got %h expected %h", sb_q[i].name, cyc, act, sb_q[i].val);
        end
        sb_q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; instr = I_NOP; stall = 1'b0; flush = 1'b0;
    zero = 1'b0; neg = 1'b0; ovf = 1'b0; carry = 1'b0;

    step(); push_all_zero("reset_state");
    step(); rst_n = 1'b1;

    step(); instr = I_SUB;
    push(0, S_ILL, 4'd0, "sub_illegal");
    push(1, S_ALU, 4'b0001, "sub_alu_e");
    push(1, S_ALUSRC, 4'd0, "sub_alusrc_e");
    push(2, S_RWM, 4'd1, "sub_regw_m");
    push(2, S_MW, 4'd0, "sub_memw_m");
    push(3, S_RWW, 4'd1, "sub_regw_w");
    push(3, S_RS, 4'd0, "sub_ressrc_w");

    step(); instr = I_LW;
    push(0, S_IMM, 4'd0, "lw_imm_src");
    push(1, S_LOAD, 4'd1, "lw_load_e");
    push(1, S_ALUSRC, 4'd1, "lw_alusrc_e");
    push(2, S_BA, 4'd0, "lw_byte_m");
    push(2, S_RWM, 4'd1, "lw_regw_m");
    push(3, S_RS, 4'd1, "lw_ressrc_w");
    push(3, S_RWW, 4'd1, "lw_regw_w");

    step(); instr = I_BLT;
    push(0, S_IMM, 4'd2, "blt_imm_src");
    push(2, S_RWM, 4'd0, "blt_regw_m");
    push(2, S_MW, 4'd0, "blt_memw_m");

    step(); instr = I_BLT; neg = 1'b1; ovf = 1'b0;
    push(0, S_PCSRC, 4'd1, "blt_taken_n1v0");

    step(); instr = I_BGEU; neg = 1'b1; ovf = 1'b1; carry = 1'b0;
    push(0, S_PCSRC, 4'd0, "blt_not_taken_n1v1");

    step(); instr = I_BLTU; carry = 1'b1;
    push(0, S_PCSRC, 4'd1, "bgeu_taken_c1");

    step(); instr = I_NOP;
    push(0, S_PCSRC, 4'd0, "bltu_not_taken_c1");
    push(1, S_ALU, 4'd0, "addi_alu_e");
    push(1, S_ALUSRC, 4'd1, "addi_alusrc_e");
    push(2, S_RWM, 4'd1, "addi_regw_m");

    step(); instr = I_JAL;
    push(0, S_IMM, 4'd3, "jal_imm_src");
    push(1, S_PCSRC, 4'd1, "jal_taken");
    push(3, S_RS, 4'd2, "jal_ressrc_w");
    push(3, S_RWW, 4'd1, "jal_regw_w");

    step(); instr = I_SB;
    push(0, S_IMM, 4'd1, "sb_imm_src");
    push(1, S_ALUSRC, 4'd1, "sb_alusrc_e");
    push(1, S_PCSRC, 4'd0, "sb_pcsrc_e");
    push(2, S_MW, 4'd1, "sb_memw_m");
    push(2, S_BA, 4'd1, "sb_byte_m");

    step(); instr = I_LW;
    push(1, S_LOAD, 4'd1, "lw2_load_e");

    step(); stall = 1'b1;
    step();
    push(0, S_MW, 4'd1, "stall1_memw_m");
    push(0, S_BA, 4'd1, "stall1_byte_m");
    push(0, S_LOAD, 4'd1, "stall1_load_e");

    step(); flush = 1'b1;
    push(0, S_MW, 4'd1, "stall2_memw_m");
    push(0, S_BA, 4'd1, "stall2_byte_m");
    push(1, S_LOAD, 4'd1, "stall_flush_e_held");
    push(1, S_MW, 4'd1, "stall3_memw_m");
    push(1, S_BA, 4'd1, "stall3_byte_m");

    step(); stall = 1'b0;
    push(1, S_LOAD, 4'd0, "flush_bubble_load");
    push(1, S_ALUSRC, 4'd0, "flush_bubble_alusrc");
    push(1, S_ALU, 4'd0, "flush_bubble_alu");
    push(1, S_MW, 4'd0, "release_memw_m");
    push(1, S_BA, 4'd0, "release_byte_m");
    push(1, S_RWM, 4'd1, "release_lw_regw_m");
    push(1, S_RWW, 4'd0, "release_sb_regw_w");

    step(); flush = 1'b0; instr = I_MUL;
    push(0, S_ILL, 4'd1, "mul_illegal_m0");
    push(0, S_ILL_M, 4'd0, "mul_legal_m1");
    push(1, S_ALU, 4'd0, "mul_bubble_alu_m0");
    push(1, S_ALU_M, 4'b1010, "mul_alu_m1");
    push(2, S_RWM, 4'd0, "mul_bubble_regw_m");

    step(); instr = I_BILL;
    push(0, S_ILL, 4'd1, "branch_f3_010_illegal");
    push(1, S_PCSRC, 4'd0, "illegal_branch_no_redirect");
    push(1, S_ALU_M, 4'd0, "illegal_branch_bubble_m1");

    step(); instr = I_SUB; zero = 1'b1;
    push(0, S_ILL, 4'd0, "sub2_illegal");

    step(); rst_n = 1'b0;
    push_all_zero("rst_async");
    #1;
    n_vec++;
    if (pc_src !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_direct_pcsrc: got %b expected 0", pc_src);
    end
    n_vec++;
    if (alu_ctl !== 4'd0) begin
      n_miss++;
      $display("FAIL rst_direct_alu: got %h expected 0", alu_ctl);
    end
    n_vec++;
    if (rw_w !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_direct_rww: got %b expected 0", rw_w);
    end
    n_vec++;
    if (res_w !== 2'd0) begin
      n_miss++;
      $display("FAIL rst_direct_ressrc: got %h expected 0", res_w);
    end
    n_vec++;
    if (mem_write !== 1'b0) begin
      n_miss++;
      $display("FAIL rst_direct_memw: got %b expected 0", mem_write);
    end
    n_vec++;
    if (alu_ctl_m !== 4'd0) begin
      n_miss++;
      $display("FAIL rst_direct_alu_extm: got %h expected 0", alu_ctl_m);
    end

    step(); stall = 1'b1; flush = 1'b1;
    push_all_zero("rst_dominates");

    step(); rst_n = 1'b1; stall = 1'b0; flush = 1'b0; instr = I_SUB;
    push(1, S_ALU, 4'b0001, "post_reset_alu_e");
    push(2, S_RWM, 4'd1, "post_reset_regw_m");
    push(3, S_RWW, 4'd1, "post_reset_regw_w");

    step(); instr = I_JALR;
    push(0, S_IMM, 4'd0, "jalr_imm_src");
    push(1, S_JALR, 4'd1, "jalr_e");
    push(1, S_PCSRC, 4'd1, "jalr_taken");
    push(1, S_ALUSRC, 4'd1, "jalr_alusrc_e");
    push(3, S_RS, 4'd2, "jalr_ressrc_w");

    step(); instr = I_NOP;
    repeat (6) step();

    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL %s: never checked, due cycle %0d expected %h", e.name, e.due, e.val);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    if (n_miss != 0) begin
      $display("FAIL: %0d miscompares", n_miss);
    end else begin
      $display("PASS");
    end
    $finish;
  end

endmodule
